pc_sequencer: RTL
=================

# pc_sequencer

Program-counter and fetch sequencer for the custom microprocessor. It owns `prog_ctr`, steps it each cycle, and loads branch targets produced by the branch-target/constant lookup stage. It feeds instruction memory and raises `done` when execution reaches the halt address. It sits directly downstream of the lookup table that supplies `target`.

## Interface
Parameters:
- `D`, 12: width of `prog_ctr` and `target`.
- `DONE_ADDR`, 511: address that terminates a program run.
- `STACK_DEPTH`, 4: return-stack entries. Used only with `PC_RETSTACK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a program run from address 0.
- `stall`  in  1  hold `prog_ctr` this cycle.
- `abs_jump_en`  in  1  taken absolute branch; load `target`.
- `call_en`  in  1  call to `target`.
- `ret_en`  in  1  return to the popped address.
- `target`  in  D  absolute branch target from the lookup stage.
- `prog_ctr`  out  D  current fetch address.
- `fetch_valid`  out  1  `prog_ctr` is a live fetch address.
- `busy`  out  1  sequencer is in RUN.
- `done`  out  1  run completed; sticky until the next `start`.
- `stack_err`  out  1  sticky return-stack overflow/underflow flag.

## Operation
States: IDLE, RUN, DONE.
- **Reset:** state IDLE; `prog_ctr`=0, `fetch_valid`=0, `busy`=0, `done`=0, `stack_err`=0; return stack emptied.
- **IDLE:**
  - `start`=1: go to RUN with `prog_ctr`=0.
  - Otherwise hold. All other inputs are ignored.
- **RUN:** `fetch_valid`=1, `busy`=1. Next-PC priority, highest first:
  1. `stall`: hold.
  2. `ret_en`: pop into `prog_ctr`.
  3. `call_en`: push `prog_ctr`+1, load `target`.
  4. `abs_jump_en`: load `target`.
  5. Otherwise: `prog_ctr`+1.
- **RUN, other rules:**
  - Increment is modulo 2^D; `2^D-1` wraps to 0 with no flag.
  - `start` is ignored.
- **Entering DONE:** whenever the next-PC value equals `DONE_ADDR`, the same edge loads `prog_ctr`=`DONE_ADDR`, enters DONE and sets `done`=1. This covers jump, increment and return alike.
- **DONE:**
  - `fetch_valid`=0, `busy`=0; `prog_ctr` holds `DONE_ADDR`.
  - `start`=1: go to RUN, `prog_ctr`=0, `done`=0. `stack_err` keeps its value. The return stack is emptied.
- **Reset mid-run:** immediate return to the reset values on that edge, regardless of other inputs.

## Timing
- All control inputs are sampled at the rising edge. The new `prog_ctr` is visible one cycle later, with no combinational path from inputs to `prog_ctr`.
- `start` to first fetch: 1 cycle. `fetch_valid` rises on the same edge that enters RUN.
- `done` rises on the same edge that `prog_ctr` becomes `DONE_ADDR`.
- A stalled cycle still detects nothing: `done` can only assert on an edge that actually changes `prog_ctr`.
- Outputs are registered, except `busy` and `fetch_valid`, which are decoded from the state register.

## Configuration
`PC_RETSTACK_EN`
- **Defined:**
  - A `STACK_DEPTH`-entry LIFO of D-bit return addresses.
  - Push on full: the oldest entry is discarded, the push succeeds, and `stack_err` is set.
  - Pop on empty: `prog_ctr` increments instead and `stack_err` is set.
  - Push and pop can never coincide, because `ret_en` outranks `call_en`.
- **Undefined:**
  - No stack storage.
  - `call_en` behaves exactly as `abs_jump_en`.
  - `ret_en` is ignored; the cycle falls through to lower priorities.
  - `stack_err` is tied to 0.

## Test plan
- **Reset and start.** Reset, then `start` pulse, then 3 free cycles.
  - After reset: `prog_ctr`=0, `fetch_valid`=0, `done`=0.
  - Then `prog_ctr` goes 0, 1, 2, 3, with `busy`=1.
- **Jump and stall.** In RUN at `prog_ctr`=0x009, assert `abs_jump_en` with `target`=0x01D, then hold `stall` for 2 cycles.
  - `prog_ctr`=0x01D, held for 2 cycles, then 0x01E.
- **Halt by jump.** `abs_jump_en` with `target`=511 from `prog_ctr`=0x049.
  - Next cycle: `prog_ctr`=511, `done`=1, `fetch_valid`=0.
  - `done` stays 1 for 10 cycles.
  - A following `start` gives `prog_ctr`=0, `done`=0.
- **Call/return** (`PC_RETSTACK_EN`). `call_en` with `target`=0x034 at `prog_ctr`=0x025, two increments, then `ret_en`.
  - `prog_ctr` sequence: 0x034, 0x035, 0x036, 0x026.
  - `stack_err`=0.
- **Stack errors** (`PC_RETSTACK_EN`).
  - 5 nested calls: `stack_err`=1 after the 5th call.
  - 5 returns: the first 4 return correctly; the 5th increments `prog_ctr` instead.
  - `ret_en` on an empty stack from reset: `prog_ctr`+1, `stack_err`=1.
- **Reset mid-run.** Assert `reset` while in RUN with `call_en` and `abs_jump_en` both high.
  - Next cycle: IDLE, `prog_ctr`=0, `stack_err`=0.
  - A `ret_en` after the next `start` underflows, showing the stack was emptied.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter and fetch sequencer: IDLE/RUN/DONE control around prog_ctr.
// Optional return stack is enabled by defining PC_RETSTACK_EN; without it
// call_en acts as an absolute jump, ret_en is ignored and stack_err reads 0.
module pc_sequencer #(
  parameter int unsigned D           = 12,
  parameter int unsigned DONE_ADDR   = 511,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         abs_jump_en,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [D-1:0] target,
  output logic [D-1:0] prog_ctr,
  output logic         fetch_valid,
  output logic         busy,
  output logic         done,
  output logic         stack_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [D-1:0] DoneAddr = D'(DONE_ADDR);

  state_e       state_q;
  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic [D-1:0] pc_inc;
  logic         done_q;

`ifdef PC_RETSTACK_EN
  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [D-1:0]    stack_q [STACK_DEPTH];
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] top_idx;
  logic [IdxW-1:0] wr_idx;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            err_set;
  logic            stack_err_q;

  assign full    = (cnt_q == CntW'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = IdxW'(cnt_q - 1'b1);
  assign wr_idx  = IdxW'(cnt_q);
`else
  // Keeps the unused inputs and parameter visible without stack hardware.
  logic [31:0] unused_cfg;
  assign unused_cfg = STACK_DEPTH ^ {31'b0, ret_en};
`endif

  assign pc_inc = pc_q + D'(1);

  // Next-PC selection in RUN; stall outranks everything, then ret, call, jump.
  always_comb begin
    pc_d = pc_inc;
`ifdef PC_RETSTACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (!stall) begin
`ifdef PC_RETSTACK_EN
      if (ret_en) begin
        if (empty) begin
          err_set = 1'b1;  // underflow falls back to an increment
        end else begin
          pop  = 1'b1;
          pc_d = stack_q[top_idx];
        end
      end else if (call_en) begin
        push    = 1'b1;
        err_set = full;
        pc_d    = target;
      end else if (abs_jump_en) begin
        pc_d = target;
      end
`else
      if (call_en || abs_jump_en) begin
        pc_d = target;
      end
`endif
    end
  end

  // Control FSM with registered prog_ctr and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= '0;
          end
        end
        StRun: begin
          // Halt is only detected on an edge that really moves prog_ctr.
          if (!stall) begin
            pc_q <= pc_d;
            if (pc_d == DoneAddr) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          if (start) begin
            state_q <= StRun;
            pc_q    <= '0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          pc_q    <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_RETSTACK_EN
  // Return-stack LIFO; a push on full drops the oldest entry at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      stack_err_q <= 1'b0;
    end else if (state_q == StDone && start) begin
      cnt_q <= '0;
    end else if (state_q == StRun) begin
      if (err_set) begin
        stack_err_q <= 1'b1;
      end
      if (push) begin
        if (full) begin
          for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) begin
            stack_q[IdxW'(i)] <= stack_q[IdxW'(i + 1)];
          end
          stack_q[IdxW'(STACK_DEPTH - 1)] <= pc_inc;
        end else begin
          stack_q[wr_idx] <= pc_inc;
          cnt_q           <= cnt_q + 1'b1;
        end
      end else if (pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign stack_err = stack_err_q;
`else
  assign stack_err = 1'b0;
`endif

  assign prog_ctr    = pc_q;
  assign done        = done_q;
  assign busy        = (state_q == StRun);
  assign fetch_valid = (state_q == StRun);

endmodule
